// File: rtl/kf8288.sv
// kf8288: 8288 bus controller, S2..S0 -> ALE, command strobes, transceiver controls; KF8288_CASCADE_EN enables MCE.
// Latency: ALE for one clock after the cycle-start sample, read/advanced strobes from the next clock, normal writes a clock later.
// Backpressure: none; CEN/AEN gate the strobe groups combinationally while the internal phase keeps running.
module kf8288 (
    input  logic       clock,
    input  logic       reset,
    input  logic       address_enable_n,
    input  logic       command_enable,
    input  logic       io_bus_mode,
    input  logic [2:0] processor_status,
    output logic       enable_io_command,
    output logic       advanced_io_write_command_n,
    output logic       io_write_command_n,
    output logic       io_read_command_n,
    output logic       interrupt_acknowledge_n,
    output logic       enable_memory_command,
    output logic       advanced_memory_write_command_n,
    output logic       memory_write_command_n,
    output logic       memory_read_command_n,
    output logic       direction_transmit_or_receive_n,
    output logic       data_enable,
    output logic       master_cascade_enable,
    output logic       peripheral_data_enable_n,
    output logic       address_latch_enable
);

    typedef enum logic [1:0] {PH_IDLE, PH_T1, PH_CMD} phase_t;
    typedef enum logic [2:0] {CY_INTA, CY_IOR, CY_IOW, CY_MEMR, CY_MEMW} cycle_t;

    localparam logic [2:0] ST_HALT    = 3'b011;
    localparam logic [2:0] ST_PASSIVE = 3'b111;

    phase_t     phase;
    cycle_t     cycle;
    logic [2:0] prev_status;
    logic       write_late;

    function automatic cycle_t decode(input logic [2:0] s);
        case (s)
            3'b000:         decode = CY_INTA;
            3'b001:         decode = CY_IOR;
            3'b010:         decode = CY_IOW;
            3'b100, 3'b101: decode = CY_MEMR;
            3'b110:         decode = CY_MEMW;
            default:        decode = CY_INTA;
        endcase
    endfunction

    wire status_passive = (processor_status == ST_PASSIVE);
    wire cycle_start    = (prev_status == ST_PASSIVE) && !status_passive
                          && (processor_status != ST_HALT);

    // Cycle type is captured only at start; later active codes are ignored until passive.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_status <= ST_PASSIVE;
            phase       <= PH_IDLE;
            cycle       <= CY_INTA;
            write_late  <= 1'b0;
        end else begin
            prev_status <= processor_status;
            case (phase)
                PH_IDLE: begin
                    if (cycle_start) begin
                        phase <= PH_T1;
                        cycle <= decode(processor_status);
                    end
                end
                PH_T1: begin
                    write_late <= 1'b0;
                    phase      <= status_passive ? PH_IDLE : PH_CMD;
                end
                PH_CMD: begin
                    if (status_passive) phase <= PH_IDLE;
                    else                write_late <= 1'b1;
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

    wire in_t1   = (phase == PH_T1);
    wire in_cmd  = (phase == PH_CMD);
    wire is_read = (cycle == CY_INTA) || (cycle == CY_IOR) || (cycle == CY_MEMR);
    wire is_io   = (cycle == CY_INTA) || (cycle == CY_IOR) || (cycle == CY_IOW);

    assign enable_memory_command = command_enable & ~address_enable_n;
    assign enable_io_command     = command_enable & (io_bus_mode | ~address_enable_n);

    assign address_latch_enable            = in_t1;
    assign direction_transmit_or_receive_n = !((in_t1 || in_cmd) && is_read);

    // In I/O bus mode the I/O-side transceiver is steered by /PDEN instead of DEN.
    assign data_enable              = command_enable && in_cmd && !(io_bus_mode && is_io);
    assign peripheral_data_enable_n = !(command_enable && in_cmd && io_bus_mode && is_io);

    assign interrupt_acknowledge_n     = !(enable_io_command && in_cmd && cycle == CY_INTA);
    assign io_read_command_n           = !(enable_io_command && in_cmd && cycle == CY_IOR);
    assign advanced_io_write_command_n = !(enable_io_command && in_cmd && cycle == CY_IOW);
    assign io_write_command_n          = !(enable_io_command && in_cmd && write_late && cycle == CY_IOW);

    assign memory_read_command_n           = !(enable_memory_command && in_cmd && cycle == CY_MEMR);
    assign advanced_memory_write_command_n = !(enable_memory_command && in_cmd && cycle == CY_MEMW);
    assign memory_write_command_n          = !(enable_memory_command && in_cmd && write_late && cycle == CY_MEMW);

`ifdef KF8288_CASCADE_EN
    assign master_cascade_enable = in_t1 && (cycle == CY_INTA) && !io_bus_mode;
`else
    assign master_cascade_enable = 1'b0;
`endif

endmodule

// File: tb/tb_kf8288.sv
// Bench for kf8288: fixed vector table, hand-written corner sequences, then random stimulus against a cycle-count model.
module tb_kf8288;
    logic       clock;
    logic       reset;
    logic       address_enable_n;
    logic       command_enable;
    logic       io_bus_mode;
    logic [2:0] processor_status;
    logic       enable_io_command, advanced_io_write_command_n, io_write_command_n;
    logic       io_read_command_n, interrupt_acknowledge_n, enable_memory_command;
    logic       advanced_memory_write_command_n, memory_write_command_n, memory_read_command_n;
    logic       direction_transmit_or_receive_n, data_enable, master_cascade_enable;
    logic       peripheral_data_enable_n, address_latch_enable;

    kf8288 dut (
        .clock(clock), .reset(reset),
        .address_enable_n(address_enable_n), .command_enable(command_enable),
        .io_bus_mode(io_bus_mode), .processor_status(processor_status),
        .enable_io_command(enable_io_command),
        .advanced_io_write_command_n(advanced_io_write_command_n),
        .io_write_command_n(io_write_command_n), .io_read_command_n(io_read_command_n),
        .interrupt_acknowledge_n(interrupt_acknowledge_n),
        .enable_memory_command(enable_memory_command),
        .advanced_memory_write_command_n(advanced_memory_write_command_n),
        .memory_write_command_n(memory_write_command_n),
        .memory_read_command_n(memory_read_command_n),
        .direction_transmit_or_receive_n(direction_transmit_or_receive_n),
        .data_enable(data_enable), .master_cascade_enable(master_cascade_enable),
        .peripheral_data_enable_n(peripheral_data_enable_n),
        .address_latch_enable(address_latch_enable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {ale, dt/r_n, den, mce, pden_n, en_io, en_mem, aiowc_n, iowc_n, iorc_n, inta_n, amwc_n, mwtc_n, mrdc_n}
    wire [13:0] got = {address_latch_enable, direction_transmit_or_receive_n, data_enable,
                       master_cascade_enable, peripheral_data_enable_n, enable_io_command,
                       enable_memory_command, advanced_io_write_command_n, io_write_command_n,
                       io_read_command_n, interrupt_acknowledge_n, advanced_memory_write_command_n,
                       memory_write_command_n, memory_read_command_n};

    localparam logic [13:0] IDLE_V = 14'b0100_111_1111111;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a bus cycle is "active" with a clock count since its start (0 = T1).
    logic [2:0] m_prev;
    bit         m_active;
    logic [2:0] m_type;
    int         m_cnt;

    task automatic check(input string name, input logic [13:0] g, input logic [13:0] e);
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, g, e);
        end
    endtask

    function automatic logic [13:0] fix_mce(input logic [13:0] e);
        logic [13:0] r;
        r = e;
`ifndef KF8288_CASCADE_EN
        r[10] = 1'b0;
`endif
        return r;
    endfunction

    task model_reset;
        m_prev = 3'b111; m_active = 0; m_type = 3'b111; m_cnt = 0;
    endtask

    task model_step(input logic [2:0] s);
        if (reset) model_reset();
        else begin
            if (m_active) begin
                if (s == 3'b111) m_active = 0;
                else m_cnt++;
            end else if (m_prev == 3'b111 && s != 3'b111 && s != 3'b011) begin
                m_active = 1; m_type = s; m_cnt = 0;
            end
            m_prev = s;
        end
    endtask

    function automatic logic [13:0] model_out(input logic cen, input logic aen, input logic iob);
        logic eio, emem, t1, cmd, rd, io, mce;
        eio  = cen & (iob | ~aen);
        emem = cen & ~aen;
        t1   = m_active && m_cnt == 0;
        cmd  = m_active && m_cnt >= 1;
        rd   = m_type inside {3'd0, 3'd1, 3'd4, 3'd5};
        io   = m_type inside {3'd0, 3'd1, 3'd2};
        mce  = t1 && m_type == 3'd0 && !iob;
        return fix_mce({t1, !((t1 || cmd) && rd), cmd && cen && !(iob && io), mce,
                        !(cmd && cen && iob && io), eio, emem,
                        !(cmd && eio && m_type == 3'd2),
                        !(cmd && eio && m_type == 3'd2 && m_cnt >= 2),
                        !(cmd && eio && m_type == 3'd1),
                        !(cmd && eio && m_type == 3'd0),
                        !(cmd && emem && m_type == 3'd6),
                        !(cmd && emem && m_type == 3'd6 && m_cnt >= 2),
                        !(cmd && emem && (m_type == 3'd4 || m_type == 3'd5))});
    endfunction

    task tick;
        @(posedge clock);
        model_step(processor_status);
        @(negedge clock);
    endtask

    typedef struct {
        logic [2:0]  st;
        logic        cen, aen, iob;
        logic [13:0] exp;
    } vec_t;
    vec_t tv[$];

    task add(input logic [2:0] st, input logic cen, input logic aen, input logic iob, input logic [13:0] e);
        vec_t v;
        v.st = st; v.cen = cen; v.aen = aen; v.iob = iob; v.exp = e;
        tv.push_back(v);
    endtask

    initial begin
        add(3'b111, 1, 0, 0, IDLE_V);
        add(3'b000, 1, 0, 0, 14'b1001_111_1111111);
        add(3'b000, 1, 0, 0, 14'b0010_111_1110111);
        add(3'b000, 1, 0, 0, 14'b0010_111_1110111);
        add(3'b111, 1, 0, 0, IDLE_V);
        add(3'b001, 1, 0, 0, 14'b1000_111_1111111);
        add(3'b001, 1, 0, 0, 14'b0010_111_1101111);
        add(3'b001, 0, 0, 0, 14'b0000_100_1111111);
        add(3'b001, 1, 0, 0, 14'b0010_111_1101111);
        add(3'b111, 1, 0, 0, IDLE_V);
        add(3'b010, 1, 0, 0, 14'b1100_111_1111111);
        add(3'b010, 1, 0, 0, 14'b0110_111_0111111);
        add(3'b010, 1, 0, 0, 14'b0110_111_0011111);
        add(3'b111, 1, 0, 0, IDLE_V);
        add(3'b011, 1, 0, 0, IDLE_V);
        add(3'b011, 1, 0, 0, IDLE_V);
        add(3'b111, 1, 0, 0, IDLE_V);
        add(3'b100, 1, 0, 0, 14'b1000_111_1111111);
        add(3'b100, 1, 0, 0, 14'b0010_111_1111110);
        add(3'b111, 1, 0, 0, IDLE_V);
        add(3'b101, 1, 0, 0, 14'b1000_111_1111111);
        add(3'b101, 1, 0, 0, 14'b0010_111_1111110);
        add(3'b111, 1, 0, 0, IDLE_V);
        add(3'b110, 1, 0, 0, 14'b1100_111_1111111);
        add(3'b110, 1, 0, 0, 14'b0110_111_1111011);
        add(3'b110, 1, 0, 0, 14'b0110_111_1111001);
        add(3'b111, 1, 0, 0, IDLE_V);
        add(3'b000, 1, 0, 1, 14'b1000_111_1111111);
        add(3'b000, 1, 0, 1, 14'b0000_011_1110111);
        add(3'b111, 1, 0, 1, IDLE_V);
        add(3'b111, 1, 1, 0, 14'b0100_100_1111111);
        add(3'b111, 1, 1, 1, 14'b0100_110_1111111);
        add(3'b111, 1, 0, 0, IDLE_V);
        add(3'b100, 1, 0, 0, 14'b1000_111_1111111);
        add(3'b110, 1, 0, 0, 14'b0010_111_1111110);
        add(3'b111, 1, 0, 0, IDLE_V);

        reset = 1; address_enable_n = 0; command_enable = 1; io_bus_mode = 0;
        processor_status = 3'b111;
        model_reset();
        #12;
        check("reset_state", got, IDLE_V);
        @(negedge clock);
        reset = 0;

        for (int i = 0; i < tv.size(); i++) begin
            processor_status = tv[i].st; command_enable = tv[i].cen;
            address_enable_n = tv[i].aen; io_bus_mode = tv[i].iob;
            tick();
            check($sformatf("vec%0d", i), got, fix_mce(tv[i].exp));
        end

        // Reset in the middle of a read cycle, then restart with status still active.
        processor_status = 3'b001; command_enable = 1; address_enable_n = 0; io_bus_mode = 0;
        tick(); tick();
        check("rst_pre", got, 14'b0010_111_1101111);
        reset = 1; model_reset();
        #1 check("rst_async", got, IDLE_V);
        tick();
        reset = 0;
        tick();
        check("rst_restart", got, 14'b1000_111_1111111);
        processor_status = 3'b111;
        tick();
        check("rst_idle", got, IDLE_V);

        // AEN toggled between edges during a memory write.
        processor_status = 3'b110;
        tick(); tick(); tick();
        check("mw_late", got, 14'b0110_111_1111001);
        address_enable_n = 1;
        #1 check("aen_gate", got, 14'b0110_100_1111111);
        address_enable_n = 0;
        #1 check("aen_restore", got, 14'b0110_111_1111001);
        processor_status = 3'b111;
        tick();
        check("mw_idle", got, IDLE_V);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(299) == 0);
            if (reset) model_reset();
            if ($urandom_range(3) == 0)
                processor_status = ($urandom_range(2) == 0) ? 3'b111 : 3'($urandom_range(7));
            command_enable   = ($urandom_range(7) != 0);
            address_enable_n = ($urandom_range(3) == 0);
            if ($urandom_range(15) == 0) io_bus_mode = ~io_bus_mode;
            tick();
            check("rand", got, model_out(command_enable, address_enable_n, io_bus_mode));
            if ($urandom_range(3) == 0) begin
                command_enable   = 1'($urandom_range(1));
                address_enable_n = 1'($urandom_range(1));
                #1 check("rand_comb", got, model_out(command_enable, address_enable_n, io_bus_mode));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
